// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: Avalon-MM controlled multi-digit seven-segment driver with blank, blink and optional hex decode.
// Ports: clk, reset_n (async, active-low); address/chipselect/write_n/writedata/readdata form the Avalon-MM slave;
// seg_out carries one registered byte per digit, bit order {dp,g,f,e,d,c,b,a}.
// Registers: 0 DIG_LO (digits 3..0), 1 DIG_HI (digits 7..4), 2 CTRL {BLINK_MASK[15:8], BLANK[1], DECODE[0]}, 3 BLINK (phase[0]).
// Build option: define SEG_HEX_DECODE_EN to include the hex decoder and make CTRL.DECODE writable.
module seg_display_ctrl #(
  parameter int          NUM_DIGITS = 6,
  parameter logic [31:0] BLINK_DIV  = 32'd25000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [8*NUM_DIGITS-1:0] seg_out
);
  // Bytes of absent digits are masked to constant zero so they are never stored and read back as 0.
  localparam logic [63:0]             DIG_MASK = {64{1'b1}} >> (64 - 8 * NUM_DIGITS);
  localparam logic [7:0]              BLK_MASK = 8'hFF >> (8 - NUM_DIGITS);
  localparam logic [8*NUM_DIGITS-1:0] SEG_OFF  = ACTIVE_LOW ? '1 : '0;
  logic [63:0]             digs;
  logic [7:0]              mask;
  logic                    blank;
  logic                    decode;
  logic                    phase;
  logic [31:0]             cnt;
  logic                    we;
  logic                    tc;
  logic [7:0]              pat;
  logic [8*NUM_DIGITS-1:0] seg_next;
  assign we = chipselect & ~write_n;
  assign tc = cnt == BLINK_DIV - 32'd1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digs  <= '0;
      mask  <= '0;
      blank <= 1'b0;
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      if (we && address == 2'd0) digs[31:0] <= writedata & DIG_MASK[31:0];
      if (we && address == 2'd1) digs[63:32] <= writedata & DIG_MASK[63:32];
      if (we && address == 2'd2) begin
        mask  <= writedata[15:8] & BLK_MASK;
        blank <= writedata[1];
      end
      // A BLINK write takes priority over the terminal-count wrap.
      if (we && address == 2'd3) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (tc) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end
`ifdef SEG_HEX_DECODE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) decode <= 1'b0;
    else if (we && address == 2'd2) decode <= writedata[0];
  end
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction
`else
  assign decode = 1'b0;
`endif
  always_comb begin
    seg_next = '0;
    pat      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SEG_HEX_DECODE_EN
      pat = decode ? {digs[8*i+7], hex7(digs[8*i+:4])} : digs[8*i+:8];
`else
      pat = digs[8*i+:8];
`endif
      pat = (blank || (phase && mask[i])) ? 8'h00 : pat;
      seg_next[8*i+:8] = ACTIVE_LOW ? ~pat : pat;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seg_out <= SEG_OFF;
    else seg_out <= seg_next;
  end
  assign readdata = address == 2'd0 ? digs[31:0] :
                    address == 2'd1 ? digs[63:32] :
                    address == 2'd2 ? {16'h0, mask, 6'h0, blank, decode} :
                                      {31'h0, phase};
endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 6: number of seven-segment digits driven, legal range 1..8.
REQ-002 Parameter BLINK_DIV, default 25000000: clk cycles per blink half-period, legal range 2..2^32-1.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = segment lit by driving 0; 0 = segment lit by driving 1.
REQ-004 clk  in  1  single clock; all state is clocked on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 address  in  2  Avalon-MM slave word address.
REQ-007 chipselect  in  1  slave select; high qualifies the access.
REQ-008 write_n  in  1  active-low write strobe.
REQ-009 writedata  in  32  write data.
REQ-010 readdata  out  32  combinational read data for the current address.
REQ-011 seg_out  out  8*NUM_DIGITS  registered segments; byte i = digit i, bit order {dp,g,f,e,d,c,b,a}.

Function
REQ-012 A write occurs on a rising edge when chipselect=1 and write_n=0; all other cycles leave registers unchanged.
REQ-013 Register map: 0 DIG_LO (bytes = digits 3..0), 1 DIG_HI (bytes = digits 7..4), 2 CTRL, 3 BLINK.
REQ-014 DIG_LO/DIG_HI bytes for digits >= NUM_DIGITS are not stored, ignore writes and read 0.
REQ-015 CTRL: bit0 DECODE, bit1 BLANK, bits[15:8] BLINK_MASK (bit i = digit i); bits for absent digits and all other bits read 0.
REQ-016 BLINK read: bit0 = blink phase, other bits 0; any write to BLINK clears blink counter and phase.
REQ-017 readdata reflects stored register contents without delay; reads have no side effects.
REQ-018 Blink counter counts 0..BLINK_DIV-1; on the cycle it equals BLINK_DIV-1 it wraps to 0 and phase toggles.
REQ-019 BLINK write coinciding with terminal count: write wins, counter=0, phase=0.
REQ-020 Digit pattern: DECODE=0 -> stored byte used as raw active-high segments; DECODE=1 -> low nibble hex-decoded (0-F), stored bit7 passed as dp.
REQ-021 Digit i is blank if BLANK=1, or phase=1 and BLINK_MASK[i]=1; blank = all 8 segments off.
REQ-022 seg_out = pattern, inverted per byte when ACTIVE_LOW=1, registered once; write at edge k is visible on seg_out after edge k+1.
REQ-023 Phase toggle at edge k affects seg_out after edge k+1.
REQ-024 Hex table (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.

Reset
REQ-025 While reset_n=0: digit, CTRL registers, counter and phase are 0.
REQ-026 While reset_n=0: seg_out drives all segments off (all ones if ACTIVE_LOW=1, all zeros otherwise).
REQ-027 Reset assertion mid-blink or mid-write aborts immediately; the first write is accepted on the first edge after deassertion.

Configuration
REQ-028 Macro SEG_HEX_DECODE_EN defined: hex decoder present, CTRL.DECODE writable and behaves per REQ-020.
REQ-029 SEG_HEX_DECODE_EN undefined: no decoder logic, CTRL.DECODE reads 0 and ignores writes, raw mode only; all else identical.

Verification
REQ-030 NUM_DIGITS=6, ACTIVE_LOW=1: release reset -> seg_out=48'hFFFF_FFFF_FFFF, readdata=0 at every address.
REQ-031 Write DIG_LO=32'h8040_2010 at edge k -> seg_out[31:0]=32'h7FBF_DFEF after edge k+1; read DIG_LO returns 32'h8040_2010.
REQ-032 SEG_HEX_DECODE_EN defined: CTRL=1, DIG_LO=32'h0000_0A81 -> digit0=~8'h86, digit1=~8'h77; macro undefined -> CTRL reads 0, digit0=~8'h81.
REQ-033 BLINK_DIV=4, CTRL=32'h0000_0100, DIG_LO=32'hFF -> digit0 alternates off/8'h00 every 4 cycles; BLINK read bit0 tracks phase.
REQ-034 Write DIG_HI=32'hFFFF_FFFF with NUM_DIGITS=6 -> readback 32'h0000_FFFF; CTRL=32'h2 -> all digits off despite data.
REQ-035 Write BLINK on terminal-count cycle -> phase reads 0, next toggle exactly BLINK_DIV cycles later; reset_n pulse mid-blink -> phase 0, seg_out all off.
